// File: rtl/key_pkg.sv
// Shared definitions for the keypad time-entry front end: key codes,
// one-hot entry state encoding, BCD range limits and a digit-position helper.
package key_pkg;

  localparam logic [3:0] KEY_EDIT    = 4'hA;
  localparam logic [3:0] KEY_CONFIRM = 4'hB;
  localparam logic [3:0] KEY_BKSP    = 4'hC;
  localparam logic [3:0] KEY_CANCEL  = 4'hD;

  localparam logic [7:0] BCD_HOUR_MAX = 8'h23;
  localparam logic [3:0] BCD_TENS_MAX = 4'h5;

  localparam logic [2:0] DIGITS_FULL = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_EDIT  = 3'b010,
    ST_CHECK = 3'b100
  } state_e;

  // Bit offset of digit slot 'pos' in the {H1,H0,M1,M0,S1,S0} buffer; slot 0 is H1.
  function automatic logic [4:0] digit_shift(input logic [2:0] pos);
    return 5'd20 - {pos, 2'b00};
  endfunction

endpackage

// File: rtl/key_time_entry_bcd_check.sv
// Combinational range check of a 24-bit HH:MM:SS BCD value.
// Digits are assumed to be 0-9; only the hour pair and the tens of
// minutes/seconds need bounding. Shared with the alarm-set path.
module time_bcd_check
  import key_pkg::*;
(
  input  logic [23:0] bcd_i,
  output logic        pass_o
);

  assign pass_o = (bcd_i[23:16] <= BCD_HOUR_MAX) &&
                  (bcd_i[15:12] <= BCD_TENS_MAX) &&
                  (bcd_i[7:4]   <= BCD_TENS_MAX);

endmodule

// File: rtl/key_time_entry.sv
// Keypad time-setting front end: gathers six BCD digits from single-cycle
// key strobes, range-checks them on confirm and issues a one-cycle load.
// Optional feature: KEY_TIME_ENTRY_TIMEOUT_EN adds an idle auto-cancel in EDIT.
module key_time_entry
  import key_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32'd500_000_000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  KEY_Value,
  input  logic        Value_en,
  output logic        EDIT_ACTIVE,
  output logic [23:0] ENTRY_BCD,
  output logic [2:0]  DIGIT_CNT,
  output logic        SET_EN,
  output logic [23:0] SET_TIME,
  output logic        ERR
);

  state_e      state_q, state_d;
  logic [23:0] entry_q, entry_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        set_en_q, set_en_d;
  logic        err_q, err_d;
  logic [23:0] set_time_q, set_time_d;
  logic        edit_active_q, edit_active_d;
  logic        pass_s;
  logic [4:0]  wr_shift_s;
  logic [4:0]  bs_shift_s;

  time_bcd_check u_check (
    .bcd_i  (entry_q),
    .pass_o (pass_s)
  );

  assign wr_shift_s = digit_shift(cnt_q);
  assign bs_shift_s = digit_shift(cnt_q - 3'd1);

`ifdef KEY_TIME_ENTRY_TIMEOUT_EN
  localparam logic [28:0] TMO_LAST = 29'(TIMEOUT_CYCLES - 32'd1);
  logic [28:0] tmo_q, tmo_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 32'd0);
`endif

  // Next-state, buffer editing and strobe generation.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    set_en_d   = 1'b0;
    err_d      = 1'b0;
    set_time_d = set_time_q;
`ifdef KEY_TIME_ENTRY_TIMEOUT_EN
    tmo_d      = 29'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Value_en && (KEY_Value == KEY_EDIT)) begin
          state_d = ST_EDIT;
          entry_d = 24'd0;
          cnt_d   = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EDIT: begin
        if (Value_en) begin
          if (KEY_Value <= 4'h9) begin
            if (cnt_q < DIGITS_FULL) begin
              entry_d = (entry_q & ~(24'hF << wr_shift_s)) |
                        ({20'd0, KEY_Value} << wr_shift_s);
              cnt_d   = cnt_q + 3'd1;
            end else begin
              cnt_d = cnt_q;
            end
          end else begin
            case (KEY_Value)
              KEY_EDIT: begin
                entry_d = 24'd0;
                cnt_d   = 3'd0;
              end
              KEY_CONFIRM: state_d = ST_CHECK;
              KEY_BKSP: begin
                if (cnt_q != 3'd0) begin
                  entry_d = entry_q & ~(24'hF << bs_shift_s);
                  cnt_d   = cnt_q - 3'd1;
                end else begin
                  cnt_d = cnt_q;
                end
              end
              KEY_CANCEL: begin
                state_d = ST_IDLE;
                entry_d = 24'd0;
                cnt_d   = 3'd0;
              end
              default: state_d = ST_EDIT;
            endcase
          end
        end else begin
`ifdef KEY_TIME_ENTRY_TIMEOUT_EN
          // Idle cycle in EDIT: count toward auto-cancel.
          if (tmo_q == TMO_LAST) begin
            state_d = ST_IDLE;
            entry_d = 24'd0;
            cnt_d   = 3'd0;
          end else begin
            tmo_d = tmo_q + 29'd1;
          end
`else
          state_d = ST_EDIT;
`endif
        end
      end
      ST_CHECK: begin
        // Key strobes arriving here are deliberately dropped.
        entry_d = 24'd0;
        cnt_d   = 3'd0;
        if (pass_s && (cnt_q == DIGITS_FULL)) begin
          set_time_d = entry_q;
          set_en_d   = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_EDIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        entry_d = 24'd0;
        cnt_d   = 3'd0;
      end
    endcase
    edit_active_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, asynchronously cleared by nRST.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= ST_IDLE;
      entry_q       <= 24'd0;
      cnt_q         <= 3'd0;
      set_en_q      <= 1'b0;
      err_q         <= 1'b0;
      set_time_q    <= 24'd0;
      edit_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      entry_q       <= entry_d;
      cnt_q         <= cnt_d;
      set_en_q      <= set_en_d;
      err_q         <= err_d;
      set_time_q    <= set_time_d;
      edit_active_q <= edit_active_d;
    end
  end

`ifdef KEY_TIME_ENTRY_TIMEOUT_EN
  // Idle-timeout counter; held at zero outside EDIT by the next-state logic.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tmo_q <= 29'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign EDIT_ACTIVE = edit_active_q;
  assign ENTRY_BCD   = entry_q;
  assign DIGIT_CNT   = cnt_q;
  assign SET_EN      = set_en_q;
  assign SET_TIME    = set_time_q;
  assign ERR         = err_q;

endmodule

// File: tb/tb_key_time_entry.sv
// Directed self-checking bench for key_time_entry.
module tb_key_time_entry;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [3:0]  KEY_Value = 4'h0;
  logic        Value_en = 1'b0;
  logic        EDIT_ACTIVE;
  logic [23:0] ENTRY_BCD;
  logic [2:0]  DIGIT_CNT;
  logic        SET_EN;
  logic [23:0] SET_TIME;
  logic        ERR;

  int n_cmp = 0;
  int n_bad = 0;

  key_time_entry #(.TIMEOUT_CYCLES(32'd100)) dut (
    .CLK(CLK), .nRST(nRST), .KEY_Value(KEY_Value), .Value_en(Value_en),
    .EDIT_ACTIVE(EDIT_ACTIVE), .ENTRY_BCD(ENTRY_BCD), .DIGIT_CNT(DIGIT_CNT),
    .SET_EN(SET_EN), .SET_TIME(SET_TIME), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One key strobe; returns at the negedge after the sampling posedge.
  task automatic press(input logic [3:0] k);
    @(negedge CLK);
    KEY_Value = k;
    Value_en  = 1'b1;
    @(negedge CLK);
    Value_en  = 1'b0;
  endtask

  task automatic outs(input string tag, input logic ea, input logic [23:0] bcd,
                      input logic [2:0] cnt, input logic se, input logic [23:0] st,
                      input logic er);
    check({tag, ".edit"}, {23'd0, EDIT_ACTIVE}, {23'd0, ea});
    check({tag, ".bcd"},  ENTRY_BCD, bcd);
    check({tag, ".cnt"},  {21'd0, DIGIT_CNT}, {21'd0, cnt});
    check({tag, ".set"},  {23'd0, SET_EN}, {23'd0, se});
    check({tag, ".time"}, SET_TIME, st);
    check({tag, ".err"},  {23'd0, ERR}, {23'd0, er});
  endtask

  initial begin
    // Reset state
    #1 outs("rst", 1'b0, 24'h0, 3'd0, 1'b0, 24'h0, 1'b0);
    @(negedge CLK); @(negedge CLK);
    nRST = 1'b1;

    // Valid entry 12:34:56
    press(4'hA);
    outs("t1.a", 1'b1, 24'h0, 3'd0, 1'b0, 24'h0, 1'b0);
    press(4'h1); press(4'h2); press(4'h3);
    outs("t1.3d", 1'b1, 24'h123000, 3'd3, 1'b0, 24'h0, 1'b0);
    press(4'h4); press(4'h5); press(4'h6);
    outs("t1.6d", 1'b1, 24'h123456, 3'd6, 1'b0, 24'h0, 1'b0);
    press(4'hB);
    outs("t1.chk", 1'b1, 24'h123456, 3'd6, 1'b0, 24'h0, 1'b0);
    @(negedge CLK);
    outs("t1.set", 1'b0, 24'h0, 3'd0, 1'b1, 24'h123456, 1'b0);
    @(negedge CLK);
    outs("t1.post", 1'b0, 24'h0, 3'd0, 1'b0, 24'h123456, 1'b0);

    // Hour 24 rejected; key 7 in CHECK (back-to-back) must be dropped
    press(4'hA);
    press(4'h2); press(4'h4); press(4'h0); press(4'h0); press(4'h0); press(4'h0);
    @(negedge CLK);
    KEY_Value = 4'hB; Value_en = 1'b1;
    @(negedge CLK);
    KEY_Value = 4'h7;
    @(negedge CLK);
    Value_en = 1'b0;
    outs("t2.err", 1'b1, 24'h0, 3'd0, 1'b0, 24'h123456, 1'b1);
    @(negedge CLK);
    outs("t2.post", 1'b1, 24'h0, 3'd0, 1'b0, 24'h123456, 1'b0);

    // Backspace at zero count, then backspace, 7th digit ignored, 14:59:59
    press(4'hC);
    outs("t3.bs0", 1'b1, 24'h0, 3'd0, 1'b0, 24'h123456, 1'b0);
    press(4'hA); press(4'h1); press(4'h3); press(4'hC);
    outs("t3.bs", 1'b1, 24'h100000, 3'd1, 1'b0, 24'h123456, 1'b0);
    press(4'h4); press(4'h5); press(4'h9); press(4'h5); press(4'h9);
    press(4'h7);
    outs("t3.7th", 1'b1, 24'h145959, 3'd6, 1'b0, 24'h123456, 1'b0);
    press(4'hB);
    @(negedge CLK);
    outs("t3.set", 1'b0, 24'h0, 3'd0, 1'b1, 24'h145959, 1'b0);

    // Boundary pass 23:59:59
    press(4'hA);
    press(4'h2); press(4'h3); press(4'h5); press(4'h9); press(4'h5); press(4'h9);
    press(4'hB);
    @(negedge CLK);
    outs("t3b.set", 1'b0, 24'h0, 3'd0, 1'b1, 24'h235959, 1'b0);

    // Minutes tens 6 rejected
    press(4'hA);
    press(4'h1); press(4'h2); press(4'h6); press(4'h0); press(4'h0); press(4'h0);
    press(4'hB);
    @(negedge CLK);
    outs("t3c.err", 1'b1, 24'h0, 3'd0, 1'b0, 24'h235959, 1'b1);

    // Short entry rejected (still in EDIT)
    press(4'h1); press(4'h2); press(4'hB);
    @(negedge CLK);
    outs("t3d.err", 1'b1, 24'h0, 3'd0, 1'b0, 24'h235959, 1'b1);

    // Key E no effect, cancel, confirm ignored in IDLE, digit ignored in IDLE
    press(4'h1); press(4'h2); press(4'hE);
    outs("t4.e", 1'b1, 24'h120000, 3'd2, 1'b0, 24'h235959, 1'b0);
    press(4'hD);
    outs("t4.cancel", 1'b0, 24'h0, 3'd0, 1'b0, 24'h235959, 1'b0);
    press(4'hB);
    @(negedge CLK);
    outs("t4.b", 1'b0, 24'h0, 3'd0, 1'b0, 24'h235959, 1'b0);
    press(4'h5);
    outs("t4.dig", 1'b0, 24'h0, 3'd0, 1'b0, 24'h235959, 1'b0);

    // Reset asserted during CHECK
    press(4'hA);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'h6);
    press(4'hB);
    nRST = 1'b0;
    #1 outs("t5.rst", 1'b0, 24'h0, 3'd0, 1'b0, 24'h0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    outs("t5.after", 1'b0, 24'h0, 3'd0, 1'b0, 24'h0, 1'b0);

`ifdef KEY_TIME_ENTRY_TIMEOUT_EN
    // Idle timeout: 100 idle cycles in EDIT return to IDLE without ERR
    press(4'hA);
    press(4'h1);
    repeat (99) @(negedge CLK);
    outs("t6.pre", 1'b1, 24'h100000, 3'd1, 1'b0, 24'h0, 1'b0);
    @(negedge CLK);
    outs("t6.tmo", 1'b0, 24'h0, 3'd0, 1'b0, 24'h0, 1'b0);
    @(negedge CLK);
    check("t6.noerr", {23'd0, ERR}, 24'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
